// File: rtl/ps2_scan_sequencer.sv
// ---------------------------------------------------------------------------
// ps2_scan_sequencer
//
// Control stage between a PS/2 byte receiver and downstream consumers. It
// folds PS/2 set-2 prefix bytes (E0 = extended, F0 = break) into single key
// events and queues those events in a small FIFO with a valid/ready output
// handshake. The receiver is throttled while the FIFO is full. A prefix that
// is never completed is abandoned after TIMEOUT_CYCLES idle clocks.
//
// Ports
//   clk, reset      system clock, asynchronous active-high reset
//   enable          1 = accept keyboard traffic (gates rx_en)
//   rx_done_tick    one-cycle pulse: rx_data holds a received byte
//   rx_data[7:0]    received scan byte
//   rx_en           registered receive enable back to the receiver
//   evt_valid       head event available
//   evt_ready       consumer accepts the head event
//   evt_code[7:0]   key code of the head event
//   evt_ext         head event was E0-prefixed
//   evt_break       head event is a key release (F0-prefixed)
//   err_tick        one-cycle pulse on a protocol error or prefix timeout
//   overflow        sticky flag: an event was lost because the FIFO was full
//   ovf_clr         synchronous clear of overflow
//   level           current FIFO occupancy
// ---------------------------------------------------------------------------
module ps2_scan_sequencer #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 4,
  parameter int CNT_W          = 17,
  localparam int PTR_W         = $clog2(FIFO_DEPTH),
  localparam int LVL_W         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             rx_done_tick,
  input  logic [7:0]       rx_data,
  output logic             rx_en,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic             err_tick,
  output logic             overflow,
  input  logic             ovf_clr,
  output logic [LVL_W-1:0] level
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    S_E0   = 2'd1,
    S_F0   = 2'd2,
    S_E0F0 = 2'd3
  } state_t;

  localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [9:0]         head_q, head_d;      // {code, ext, brk}
  logic               rx_en_q, rx_en_d;
  logic               err_tick_q, err_tick_d;
  logic               overflow_q, overflow_d;
  logic [9:0]         fifo_q [FIFO_DEPTH];

  logic               is_e0, is_f0, is_bad;
  logic               timeout;
  logic               emit, emit_ext, emit_brk, err;
  logic               pop, push_ok;
  logic [9:0]         new_evt;

  assign is_e0   = (rx_data == 8'hE0);
  assign is_f0   = (rx_data == 8'hF0);
  assign is_bad  = (rx_data == 8'h00) || (rx_data == 8'hFF);
  // A byte arriving in the timeout cycle takes precedence over the timeout.
  assign timeout = !rx_done_tick && (state_q != IDLE) && (cnt_q == TO_LAST);
  assign new_evt = {rx_data, emit_ext, emit_brk};

  // Prefix decoder: at most one of emit / err per cycle.
  always_comb begin
    state_d  = state_q;
    emit     = 1'b0;
    emit_ext = 1'b0;
    emit_brk = 1'b0;
    err      = 1'b0;
    if (rx_done_tick) begin
      case (state_q)
        IDLE: begin
          if (is_e0)       state_d = S_E0;
          else if (is_f0)  state_d = S_F0;
          else if (is_bad) err     = 1'b1;
          else             emit    = 1'b1;
        end
        S_E0: begin
          if (is_e0) begin
            state_d = S_E0;
          end else if (is_f0) begin
            state_d = S_E0F0;
          end else if (is_bad) begin
            err     = 1'b1;
            state_d = IDLE;
          end else begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            state_d  = IDLE;
          end
        end
        S_F0: begin
          state_d = IDLE;
          if (is_e0 || is_f0 || is_bad) begin
            err = 1'b1;
          end else begin
            emit     = 1'b1;
            emit_brk = 1'b1;
          end
        end
        S_E0F0: begin
          state_d = IDLE;
          if (is_e0 || is_f0 || is_bad) begin
            err = 1'b1;
          end else begin
            emit     = 1'b1;
            emit_ext = 1'b1;
            emit_brk = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout) begin
      err     = 1'b1;
      state_d = IDLE;
    end
  end

  // Prefix timeout counter only runs while a sequence is partially received.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (rx_done_tick || (state_q == IDLE) || timeout) cnt_d = '0;
  end

  // FIFO control. A pop in the same cycle frees a slot for a push even when full.
  always_comb begin
    pop      = (level_q != '0) && evt_ready;
    push_ok  = emit && ((level_q < DEPTH_L) || pop);
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    level_d = level_q;
    if (push_ok && !pop)      level_d = level_q + LVL_W'(1);
    else if (!push_ok && pop) level_d = level_q - LVL_W'(1);

    // Head register mirrors the entry that will be at the read pointer after
    // this edge; a push into an empty (or emptying) FIFO bypasses storage.
    head_d = head_q;
    if (push_ok && ((level_q == '0) || (pop && (level_q == LVL_W'(1)))))
      head_d = new_evt;
    else if (pop && (level_q > LVL_W'(1)))
      head_d = fifo_q[rd_ptr_d];

    overflow_d = overflow_q;
    if (emit && !push_ok) overflow_d = 1'b1;
    else if (ovf_clr)     overflow_d = 1'b0;

    rx_en_d    = enable && (level_q < DEPTH_L);
    err_tick_d = err;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      head_q     <= '0;
      rx_en_q    <= 1'b0;
      err_tick_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      head_q     <= head_d;
      rx_en_q    <= rx_en_d;
      err_tick_q <= err_tick_d;
      overflow_q <= overflow_d;
    end
  end

  // Event storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= new_evt;
  end

  assign rx_en     = rx_en_q;
  assign evt_valid = (level_q != '0);
  assign evt_code  = head_q[9:2];
  assign evt_ext   = head_q[1];
  assign evt_break = head_q[0];
  assign err_tick  = err_tick_q;
  assign overflow  = overflow_q;
  assign level     = level_q;

endmodule

// File: tb/tb_ps2_scan_sequencer.sv
module tb_ps2_scan_sequencer;
  localparam int TO    = 64;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset, enable, rx_done_tick, evt_ready, ovf_clr;
  logic [7:0]    rx_data;
  logic          rx_en, evt_valid, evt_ext, evt_break, err_tick, overflow;
  logic [7:0]    evt_code;
  logic [LW-1:0] level;

  int n_tests = 0;
  int n_fail  = 0;
  int err_cnt = 0;
  logic [9:0] got[$];

  // Reference model state: pending prefix bytes, expected events, errors
  logic [7:0] pfx[$];
  logic [9:0] exp_q[$];
  int model_err = 0;

  always #5 clk = ~clk;

  ps2_scan_sequencer #(.TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH), .CNT_W(17)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rx_done_tick(rx_done_tick),
    .rx_data(rx_data), .rx_en(rx_en), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_code(evt_code), .evt_ext(evt_ext), .evt_break(evt_break),
    .err_tick(err_tick), .overflow(overflow), .ovf_clr(ovf_clr), .level(level)
  );

  // Monitor: counts error pulses and records every accepted event.
  always @(negedge clk) begin
    if (!reset) begin
      if (err_tick) err_cnt++;
      if (evt_valid && evt_ready) got.push_back({evt_code, evt_ext, evt_break});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 1000000", $time);
    $fatal(1);
  end

  task automatic tick_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_done_tick = 1'b1;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
  endtask

  // Set-2 prefix rules expressed on the list of pending prefix bytes.
  task automatic model_byte(input logic [7:0] b);
    logic ext, brk;
    if (b == 8'h00 || b == 8'hFF) begin
      model_err++; pfx.delete();
    end else if (b == 8'hE0) begin
      if (pfx.size() == 0 || (pfx.size() == 1 && pfx[0] == 8'hE0)) begin
        pfx.delete(); pfx.push_back(8'hE0);
      end else begin
        model_err++; pfx.delete();
      end
    end else if (b == 8'hF0) begin
      if (pfx.size() == 0 || (pfx.size() == 1 && pfx[0] == 8'hE0)) pfx.push_back(8'hF0);
      else begin model_err++; pfx.delete(); end
    end else begin
      ext = 1'b0; brk = 1'b0;
      foreach (pfx[i]) begin
        if (pfx[i] == 8'hE0) ext = 1'b1;
        if (pfx[i] == 8'hF0) brk = 1'b1;
      end
      exp_q.push_back({b, ext, brk});
      pfx.delete();
    end
  endtask

  task automatic test_reset();
    #12;
    n_tests++;
    if ({rx_en, evt_valid, evt_code, evt_ext, evt_break, err_tick, overflow, level} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got rx_en=%b vld=%b code=%h ext=%b brk=%b err=%b ovf=%b lvl=%0d, required all 0",
               rx_en, evt_valid, evt_code, evt_ext, evt_break, err_tick, overflow, level);
    end
    @(posedge clk); #1; reset = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_tests++;
    if (rx_en !== 1'b0) begin n_fail++; $display("FAIL rx_en_disabled: got %b required 0", rx_en); end
    enable = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_tests++;
    if (rx_en !== 1'b1) begin n_fail++; $display("FAIL rx_en_enabled: got %b required 1", rx_en); end
  endtask

  task automatic test_make_break();
    int e0 = err_cnt;
    evt_ready = 1'b1;
    tick_byte(8'h1C);
    n_tests++;
    if ({evt_valid, evt_code, evt_ext, evt_break} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL make_1c: got vld=%b %h/%b/%b required 1 1c/0/0", evt_valid, evt_code, evt_ext, evt_break);
    end
    tick_byte(8'hF0);
    n_tests++;
    if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL prefix_no_event: got vld=%b required 0", evt_valid); end
    tick_byte(8'h1C);
    n_tests++;
    if ({evt_valid, evt_code, evt_ext, evt_break} !== {1'b1, 8'h1C, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL break_1c: got vld=%b %h/%b/%b required 1 1c/0/1", evt_valid, evt_code, evt_ext, evt_break);
    end
    @(posedge clk); #1;
    n_tests++;
    if (err_cnt !== e0) begin n_fail++; $display("FAIL make_break_err: got %0d err pulses required 0", err_cnt - e0); end
  endtask

  task automatic test_extended();
    tick_byte(8'hE0);
    tick_byte(8'h75);
    n_tests++;
    if ({evt_valid, evt_code, evt_ext, evt_break} !== {1'b1, 8'h75, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL ext_make: got vld=%b %h/%b/%b required 1 75/1/0", evt_valid, evt_code, evt_ext, evt_break);
    end
    tick_byte(8'hE0);
    tick_byte(8'hF0);
    tick_byte(8'h75);
    n_tests++;
    if ({evt_valid, evt_code, evt_ext, evt_break} !== {1'b1, 8'h75, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL ext_break: got vld=%b %h/%b/%b required 1 75/1/1", evt_valid, evt_code, evt_ext, evt_break);
    end
    @(posedge clk); #1;
    n_tests++;
    if (level !== LW'(0)) begin n_fail++; $display("FAIL ext_level: got %0d required 0", level); end
  endtask

  task automatic test_overflow();
    evt_ready = 1'b0;
    tick_byte(8'h15);
    tick_byte(8'h1D);
    tick_byte(8'h24);
    tick_byte(8'h2D);
    n_tests++;
    if ({level, rx_en} !== {LW'(4), 1'b1}) begin
      n_fail++; $display("FAIL full_level: got lvl=%0d rx_en=%b required 4 1", level, rx_en);
    end
    @(posedge clk); #1;
    n_tests++;
    if (rx_en !== 1'b0) begin n_fail++; $display("FAIL rx_en_throttle: got %b required 0", rx_en); end
    tick_byte(8'h2C);
    n_tests++;
    if ({overflow, level, evt_code} !== {1'b1, LW'(4), 8'h15}) begin
      n_fail++; $display("FAIL overflow_set: got ovf=%b lvl=%0d head=%h required 1 4 15", overflow, level, evt_code);
    end
    @(posedge clk); #1; ovf_clr = 1'b1;
    @(posedge clk); #1; ovf_clr = 1'b0;
    n_tests++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL overflow_clr: got %b required 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_c[5];
    exp_c = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h33};
    got.delete();
    @(posedge clk); #1;
    evt_ready = 1'b1; rx_data = 8'h33; rx_done_tick = 1'b1;
    @(posedge clk); #1;
    rx_done_tick = 1'b0; evt_ready = 1'b0;
    n_tests++;
    if ({level, overflow, evt_code} !== {LW'(4), 1'b0, 8'h1D}) begin
      n_fail++; $display("FAIL push_pop_full: got lvl=%0d ovf=%b head=%h required 4 0 1d", level, overflow, evt_code);
    end
    evt_ready = 1'b1;
    for (int i = 0; i < 20 && level !== LW'(0); i++) begin @(posedge clk); #1; end
    n_tests++;
    if (level !== LW'(0)) begin n_fail++; $display("FAIL drain_timeout: got lvl=%0d required 0", level); end
    n_tests++;
    if (got.size() != 5) begin n_fail++; $display("FAIL drain_count: got %0d events required 5", got.size()); end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      n_tests++;
      if (got[i] !== {exp_c[i], 2'b00}) begin
        n_fail++; $display("FAIL drain_order[%0d]: got %h required %h", i, got[i], {exp_c[i], 2'b00});
      end
    end
  endtask

  task automatic test_timeout();
    int e0 = err_cnt;
    evt_ready = 1'b1;
    tick_byte(8'hE0);
    repeat (TO - 1) @(posedge clk); #1;
    n_tests++;
    if (err_tick !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got err=%b required 0", err_tick); end
    @(posedge clk); #1;
    n_tests++;
    if (err_tick !== 1'b1) begin n_fail++; $display("FAIL timeout_pulse: got err=%b required 1", err_tick); end
    repeat (5) @(posedge clk); #1;
    n_tests++;
    if (err_cnt !== e0 + 1) begin n_fail++; $display("FAIL timeout_once: got %0d pulses required 1", err_cnt - e0); end
    tick_byte(8'h1C);
    n_tests++;
    if ({evt_valid, evt_code, evt_ext, evt_break} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL after_timeout: got vld=%b %h/%b/%b required 1 1c/0/0", evt_valid, evt_code, evt_ext, evt_break);
    end
  endtask

  task automatic test_protocol_errors();
    int e0;
    @(posedge clk); #1;
    e0 = err_cnt;
    tick_byte(8'hF0);
    tick_byte(8'hE0);
    n_tests++;
    if ({err_tick, evt_valid} !== 2'b10) begin
      n_fail++; $display("FAIL f0_e0: got err=%b vld=%b required 1 0", err_tick, evt_valid);
    end
    tick_byte(8'h00);
    n_tests++;
    if ({err_tick, evt_valid} !== 2'b10) begin
      n_fail++; $display("FAIL idle_00: got err=%b vld=%b required 1 0", err_tick, evt_valid);
    end
    tick_byte(8'hE0);
    tick_byte(8'hFF);
    @(posedge clk); #1;
    n_tests++;
    if (err_cnt !== e0 + 3 || level !== LW'(0)) begin
      n_fail++; $display("FAIL proto_total: got %0d pulses lvl=%0d required 3 0", err_cnt - e0, level);
    end
  endtask

  task automatic test_reset_midseq();
    evt_ready = 1'b0;
    tick_byte(8'h15);
    tick_byte(8'h1D);
    tick_byte(8'hE0);
    tick_byte(8'hF0);
    n_tests++;
    if (level !== LW'(2)) begin n_fail++; $display("FAIL midseq_level: got %0d required 2", level); end
    @(posedge clk); #1; reset = 1'b1;
    #2;
    n_tests++;
    if ({rx_en, evt_valid, evt_code, evt_ext, evt_break, err_tick, overflow, level} !== '0) begin
      n_fail++; $display("FAIL midseq_reset: got rx_en=%b vld=%b code=%h ext=%b brk=%b err=%b ovf=%b lvl=%0d, required all 0",
                         rx_en, evt_valid, evt_code, evt_ext, evt_break, err_tick, overflow, level);
    end
    @(posedge clk); #1; reset = 1'b0;
    repeat (2) @(posedge clk); #1;
    tick_byte(8'h1C);
    n_tests++;
    if ({evt_valid, level, evt_code, evt_ext, evt_break} !== {1'b1, LW'(1), 8'h1C, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL after_reset: got vld=%b lvl=%0d %h/%b/%b required 1 1 1c/0/0",
                         evt_valid, level, evt_code, evt_ext, evt_break);
    end
    evt_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_random();
    int e0;
    int r;
    logic [7:0] b;
    got.delete(); exp_q.delete(); pfx.delete(); model_err = 0;
    e0 = err_cnt;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2)       b = 8'hE0;
      else if (r < 4)  b = 8'hF0;
      else if (r == 4) b = ($urandom_range(0, 1) == 1) ? 8'h00 : 8'hFF;
      else begin
        b = 8'($urandom_range(1, 254));
        if (b == 8'hE0 || b == 8'hF0) b = 8'h1C;
      end
      model_byte(b);
      @(posedge clk); #1;
      rx_data = b; rx_done_tick = 1'b1; evt_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      rx_done_tick = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        evt_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      evt_ready = 1'b1;
      @(posedge clk); #1;
    end
    repeat (5) @(posedge clk); #1;
    n_tests++;
    if (got.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rand_count: got %0d events required %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (got[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rand_event[%0d]: got %h required %h", i, got[i], exp_q[i]);
      end
    end
    n_tests++;
    if (err_cnt - e0 != model_err) begin
      n_fail++; $display("FAIL rand_errors: got %0d required %0d", err_cnt - e0, model_err);
    end
    n_tests++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL rand_overflow: got %b required 0", overflow); end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; rx_done_tick = 1'b0; rx_data = 8'h00;
    evt_ready = 1'b0; ovf_clr = 1'b0;
    test_reset();
    test_make_break();
    test_extended();
    test_overflow();
    test_full_push_pop();
    test_timeout();
    test_protocol_errors();
    test_reset_midseq();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
